// File: rtl/regfile_dump.sv
// regfile_dump: read-side initiator for the processor register file.
// On a start pulse it reads registers 0..NUM_REGS-1 in ascending order through
// one read port and streams the bytes over a valid/ready byte interface.
//
// Optional build macro: DUMP_CHECKSUM_EN -- appends one checksum beat (sum of
// all dumped bytes modulo 2**DATA_W) that carries dump_last instead of the
// final register beat.
//
// Parameters: DATA_W byte width, ADDR_W address width,
//             NUM_REGS registers per dump (1 <= NUM_REGS <= 2**ADDR_W).
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         dump request, sampled only in IDLE
//   busy          high from the cycle after start is accepted until done
//   rf_read_addr  register file read address
//   rf_read_data  combinational read data for rf_read_addr
//   dump_data     stream byte (registered)
//   dump_valid    stream byte valid
//   dump_ready    sink accepts byte
//   dump_last     final beat marker, qualified by dump_valid
//   done          one-cycle pulse after the final beat is accepted
module regfile_dump #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last,
    output logic              done
);

`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned NUM_BEATS = NUM_REGS + 1;
`else
    localparam int unsigned NUM_BEATS = NUM_REGS;
`endif
    localparam int unsigned CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_REG  = CNT_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                valid_nxt, last_nxt, busy_nxt, done_nxt;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum, sum_nxt;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rf_read_addr <= '0;
            dump_data    <= '0;
            dump_valid   <= 1'b0;
            dump_last    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rf_read_addr <= addr_nxt;
            dump_data    <= data_nxt;
            dump_valid   <= valid_nxt;
            dump_last    <= last_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running byte sum for the checksum beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else begin
            sum <= sum_nxt;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = rf_read_addr;
        data_nxt  = dump_data;
        valid_nxt = dump_valid;
        last_nxt  = dump_last;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        sum_nxt   = sum;
`endif
        unique case (state)
            IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    state_nxt = FETCH;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
`ifdef DUMP_CHECKSUM_EN
                    sum_nxt   = '0;
`endif
                end
            end
            FETCH: begin
                valid_nxt = 1'b1;
                state_nxt = SEND;
                last_nxt  = (cnt == LAST_BEAT);
`ifdef DUMP_CHECKSUM_EN
                // The beat after the last register carries the sum, not a read
                if (cnt == CNT_W'(NUM_REGS)) begin
                    data_nxt = sum;
                end else begin
                    data_nxt = rf_read_data;
                    sum_nxt  = sum + rf_read_data;
                end
`else
                data_nxt = rf_read_data;
`endif
            end
            SEND: begin
                if (dump_valid && dump_ready) begin
                    valid_nxt = 1'b0;
                    if (dump_last) begin
                        state_nxt = FINISH;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                        cnt_nxt   = cnt + CNT_W'(1);
                        // Address holds at the last register during the checksum beat
                        if (cnt < LAST_REG) begin
                            addr_nxt = ADDR_W'(cnt + CNT_W'(1));
                        end
                    end
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                last_nxt  = 1'b0;
                addr_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: register file model, randomized sink and
// directed scenarios checked against a queue-based expected stream.
module tb_regfile_dump;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_REGS = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NB = NUM_REGS + CK;

    typedef logic [7:0] byte_q_t[$];
    typedef bit         bit_q_t[$];

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic              dump_last;
    logic              done;

    logic [7:0] regs [NUM_REGS];

    int n_cmp  = 0;
    int n_fail = 0;

    assign rf_read_data = regs[rf_read_addr];

    always #5 clk = ~clk;

    regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_last(dump_last), .done(done)
    );

    // Expected stream: every register in order, then the byte sum if enabled
    function automatic byte_q_t expected_stream();
        byte_q_t q;
        logic [7:0] s;
        q = {};
        s = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            q.push_back(regs[i]);
            s = s + regs[i];
        end
        if (CK != 0) q.push_back(s);
        return q;
    endfunction

    task automatic set_regs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        regs[0] = a; regs[1] = b; regs[2] = c; regs[3] = d;
    endtask

    // Issue a start pulse; returns in cycle 1 (one edge after acceptance)
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive the sink and gather accepted beats until done or the budget expires
    task automatic collect(input bit rnd_ready, input int max_cyc,
                           output byte_q_t beats, output bit_q_t lasts,
                           output int dones, output int overlap, output bit timeout);
        beats = {}; lasts = {}; dones = 0; overlap = 0; timeout = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (dump_valid && dump_ready) begin
                beats.push_back(dump_data);
                lasts.push_back(dump_last);
            end
            if (done) dones++;
            if (done && dump_valid) overlap++;
            @(posedge clk); #1;
            if (dones > 0) begin
                timeout = 1'b0;
                break;
            end
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, dump_valid, dump_last, done, dump_data, rf_read_addr} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c=%0d got busy=%b valid=%b last=%b done=%b data=%h addr=%h exp all 0",
                         c, busy, dump_valid, dump_last, done, dump_data, rf_read_addr);
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || dump_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release c=%0d got busy=%b valid=%b exp 0 0", c, busy, dump_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    // Cycle-exact check of beat, last, busy and done timing at full ready
    task automatic test_basic();
        byte_q_t exp;
        bit ev, eb, ed;
        int k;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        exp = expected_stream();
        dump_ready = 1'b1;
        do_start();
        for (int c = 1; c <= 2 * NB + 3; c++) begin
            @(negedge clk);
            ev = (c % 2 == 0) && (c <= 2 * NB);
            eb = (c >= 1) && (c <= 2 * NB + 1);
            ed = (c == 2 * NB + 1);
            k  = c / 2 - 1;
            n_cmp++;
            if (dump_valid !== ev) begin
                n_fail++;
                $display("FAIL basic_valid c=%0d got %b exp %b", c, dump_valid, ev);
            end
            n_cmp++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, eb);
            end
            n_cmp++;
            if (done !== ed) begin
                n_fail++;
                $display("FAIL basic_done c=%0d got %b exp %b", c, done, ed);
            end
            if (ev) begin
                n_cmp++;
                if (dump_data !== exp[k]) begin
                    n_fail++;
                    $display("FAIL basic_data c=%0d got %h exp %h", c, dump_data, exp[k]);
                end
                n_cmp++;
                if (dump_last !== (k == NB - 1)) begin
                    n_fail++;
                    $display("FAIL basic_last c=%0d got %b exp %b", c, dump_last, (k == NB - 1));
                end
            end
            @(posedge clk); #1;
        end
        dump_ready = 1'b0;
    endtask

    // Stall beat 0x22 for three cycles; also write reg1 (already captured) and reg3 (not yet fetched)
    task automatic test_backpressure();
        byte_q_t got, exp;
        logic [7:0] s;
        int dones;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        got = {}; dones = 0;
        do_start();
        for (int c = 1; c <= 2 * NB + 8; c++) begin
            dump_ready = !(c >= 4 && c <= 6);
            if (c == 5) begin
                regs[1] = 8'h99;
                regs[3] = 8'h77;
            end
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                n_cmp++;
                if (dump_valid !== 1'b1 || dump_data !== 8'h22 || rf_read_addr !== 2'd1) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d got valid=%b data=%h addr=%0d exp 1 22 1",
                             c, dump_valid, dump_data, rf_read_addr);
                end
            end
            if (dump_valid && dump_ready) got.push_back(dump_data);
            if (done) dones++;
            @(posedge clk); #1;
        end
        dump_ready = 1'b0;
        exp = '{8'h11, 8'h22, 8'h33, 8'h77};
        s = 8'h11 + 8'h22 + 8'h33 + 8'h77;
        if (CK != 0) exp.push_back(s);
        n_cmp++;
        if (got.size() != exp.size() || dones != 1) begin
            n_fail++;
            $display("FAIL bp_count got beats=%0d dones=%0d exp beats=%0d dones=1", got.size(), dones, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL bp_data beat=%0d got %h exp %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        int beats, dones;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        beats = 0; dones = 0;
        dump_ready = 1'b1;
        do_start();
        for (int c = 1; c <= 2 * NB + 6; c++) begin
            start = (c == 3 || c == 9);
            @(negedge clk);
            if (dump_valid && dump_ready) beats++;
            if (done) dones++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        dump_ready = 1'b0;
        n_cmp++;
        if (beats != NB || dones != 1) begin
            n_fail++;
            $display("FAIL ign_start_count got beats=%0d dones=%0d exp %0d 1", beats, dones, NB);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_start_idle got busy=%b valid=%b exp 0 0", busy, dump_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        byte_q_t beats;
        bit_q_t lasts;
        int dones, overlap;
        bit to;
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        dump_ready = 1'b1;
        do_start();
        // Beat 0x22 is accepted at edge 4; cycle 6 presents 0x33
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        n_cmp++;
        if (dump_valid !== 1'b1 || dump_data !== 8'h33) begin
            n_fail++;
            $display("FAIL mid_reset_pre got valid=%b data=%h exp 1 33", dump_valid, dump_data);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_read_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async got valid=%b busy=%b done=%b addr=%0d exp 0 0 0 0",
                     dump_valid, busy, done, rf_read_addr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || dump_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet c=%0d got done=%b valid=%b exp 0 0", c, done, dump_valid);
            end
            @(posedge clk); #1;
        end
        do_start();
        collect(1'b0, 4 * NB + 10, beats, lasts, dones, overlap, to);
        n_cmp++;
        if (to || beats.size() != NB || beats[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL mid_reset_restart got timeout=%b beats=%0d first=%h exp 0 %0d 11",
                     to, beats.size(), (beats.size() > 0) ? beats[0] : 8'hxx, NB);
        end
    endtask

    // Random register contents and random sink readiness against the model
    task automatic test_random();
        byte_q_t exp, beats;
        bit_q_t lasts;
        int dones, overlap;
        bit to, ok;
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
            exp = expected_stream();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            do_start();
            collect(1'b1, 400, beats, lasts, dones, overlap, to);
            n_cmp++;
            if (to || dones != 1 || overlap != 0 || beats.size() != exp.size()) begin
                n_fail++;
                $display("FAIL rand_shape it=%0d got timeout=%b dones=%0d overlap=%0d beats=%0d exp 0 1 0 %0d",
                         it, to, dones, overlap, beats.size(), exp.size());
            end else begin
                ok = 1'b1;
                for (int i = 0; i < exp.size(); i++) begin
                    if (beats[i] !== exp[i] || lasts[i] !== (i == exp.size() - 1)) ok = 1'b0;
                end
                n_cmp++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand_stream it=%0d got %p last %p exp %p", it, beats, lasts, exp);
                end
            end
        end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        byte_q_t beats;
        bit_q_t lasts;
        int dones, overlap;
        bit to;
        set_regs(8'hFF, 8'h01, 8'h80, 8'h80);
        do_start();
        collect(1'b0, 40, beats, lasts, dones, overlap, to);
        n_cmp++;
        if (to || beats.size() != 5 || beats[4] !== 8'h00 || lasts[4] !== 1'b1 || lasts[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_wrap got timeout=%b beats=%0d sum=%h exp 0 5 00 with last on beat 4",
                     to, beats.size(), (beats.size() > 4) ? beats[4] : 8'hxx);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_mid_reset();
        test_random();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Read-side initiator for the 4x8 processor register file; the write port belongs to the datapath, this block owns one read port.
- On a start pulse, reads every register in ascending address order and streams the bytes out over a valid/ready byte interface for debug, trace and self-test.
- Sits beside the register file. Its read address drives one read port; that port's combinational read data returns to this block.

Parameters:
- DATA_W, 8, register and stream byte width.
- ADDR_W, 2, register address width.
- NUM_REGS, 4, registers dumped per request; must be <= 2**ADDR_W and >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  dump request, sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- rf_read_addr  output  ADDR_W  address to the register file read port.
- rf_read_data  input  DATA_W  combinational read data for rf_read_addr.
- dump_data  output  DATA_W  stream byte, registered.
- dump_valid  output  1  stream byte valid.
- dump_ready  input  1  sink accepts byte.
- dump_last  output  1  marks the final beat, qualified by dump_valid.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values (reset_n low): state=IDLE, rf_read_addr=0, dump_data=0, dump_valid=0, dump_last=0, busy=0, done=0.
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE: rf_read_addr=0. When start=1 at a clock edge: go to FETCH, busy=1, address counter=0.
- FETCH (1 cycle):
  - rf_read_addr = counter.
  - At the edge: dump_data <= rf_read_data, dump_valid <= 1, dump_last <= (counter==NUM_REGS-1), go to SEND.
- SEND:
  - dump_data, dump_last and rf_read_addr stay stable while dump_valid=1 and dump_ready=0.
  - On dump_valid & dump_ready: dump_valid <= 0.
  - If this was the last beat, go to FINISH. Otherwise counter+1 and go to FETCH.
- FINISH (1 cycle): done=1. busy <= 0 at its edge, then go to IDLE.
- Throughput: one byte per 2 cycles at full ready. First dump_valid appears 2 cycles after the start edge.
- Snapshot semantics: each byte is captured at its own FETCH edge. Register writes landing after that edge do not alter the byte already captured. Writes to not-yet-fetched registers are visible in the dump.
- start while busy=1 or in FINISH is ignored and not queued.
- dump_ready is ignored when dump_valid=0.
- Address counter never wraps past NUM_REGS-1 within a dump.
- reset_n asserted mid-dump: immediate return to reset values. No partial done. The stream is abandoned; the sink must discard a beat without dump_last.
- done and dump_valid are never high in the same cycle.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - After the last register beat, one extra beat carries the running sum of all dumped bytes, modulo 2**DATA_W. The sum is cleared on start acceptance.
  - dump_last moves to the checksum beat only; register beats all have dump_last=0.
  - Checksum beat follows the same FETCH/SEND timing and backpressure rules.
- Undefined: no checksum logic, no extra beat; dump_last is on register NUM_REGS-1.

Test Plan:
- Reset: hold reset_n=0 with start=1 -> all outputs 0, no beats. Release reset_n -> IDLE, busy=0.
- Basic dump: registers = 0x11,0x22,0x33,0x44, dump_ready=1, start pulse at edge 0.
  - Beats 0x11,0x22,0x33,0x44 in cycles 2,4,6,8.
  - dump_last only with 0x44; done in cycle 9; busy high in cycles 1-9.
- Backpressure: same data, dump_ready=0 for 3 cycles on beat 0x22 -> dump_data holds 0x22 and rf_read_addr holds 1 for those cycles; sequence and count unchanged.
- Ignored start: start pulses during cycles 3 and 9 of a dump -> exactly 4 beats, one done, returns to IDLE.
- Mid-dump reset: reset_n low after beat 0x22 is accepted -> dump_valid=0 and busy=0 asynchronously, no done. A new start afterwards dumps from 0x11.
- DUMP_CHECKSUM_EN: data 0x11,0x22,0x33,0x44 -> 5th beat 0xAA with dump_last. With data 0xFF,0x01,0x80,0x80, checksum is 0x00.
